spike_rate_decoder: RTL and testbench
=====================================

# spike_rate_decoder

Spike-train-to-value decoder on the output side of the LIF neuron: it samples the neuron's 1-bit `spike` output and measures two things over fixed windows.
- the number of spikes per window (rate code);
- the most recent inter-spike interval (ISI).

Each completed window's results are presented on a valid/ready output port, so a host or readout stage can recover a numeric value from the spike train the neuron produces.

## Interface
- `WINDOW`, default 64: window length in enabled clock cycles; legal range 2..65535.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset_n`  input  1  reset; asynchronous, active-low.
- `spike`  input  1  spike pulse from the neuron; sampled as a level every cycle.
- `enable`  input  1  1 = measure; 0 = abort and hold the measurement logic idle.
- `rate_out`  output  8  spike count of the last delivered window, saturating at 255.
- `isi_out`  output  8  last ISI, in cycles, measured up to the end of that window; saturating at 255; 0 = fewer than two spikes seen since enable rose.
- `out_valid`  output  1  `rate_out` and `isi_out` hold an unconsumed result.
- `out_ready`  input  1  consumer accepts the result.
- `overrun`  output  1  sticky flag: a window result was dropped because the output register was still occupied.

## Operation
- **Input register:** `spike` is registered into `spike_q` every cycle, regardless of `enable`. All counting uses `spike_q`.
- **States:**
  - `IDLE` (`enable`=0).
  - `COUNT` (`enable`=1).
  - Transitions:
    - `IDLE`→`COUNT` on `enable`=1.
    - `COUNT`→`IDLE` on `enable`=0.
- **In `IDLE`:**
  - `win_cnt` = 0, `spk_cnt` = 0, `isi_cnt` = 0, `have_prev` = 0.
  - The output register and `out_valid` are untouched, so a pending result stays until accepted.
- **In `COUNT`, each cycle:**
  - `win_cnt` increments.
  - If `spike_q` = 1, `spk_cnt` increments, saturating at 255.
- **ISI measurement:**
  - `isi_cnt` increments every `COUNT` cycle, saturating at 255.
  - On a cycle with `spike_q` = 1:
    - if `have_prev` = 1, `isi_last` ← `isi_cnt` (the saturated value);
    - then `isi_cnt` ← 1 and `have_prev` ← 1.
  - `isi_last` clears to 0 when entering `IDLE`.
- **Window end:** the cycle where `win_cnt` = `WINDOW`−1.
  - `result_rate` = `spk_cnt` + `spike_q`, saturated at 255.
  - `result_isi` = the value `isi_last` takes in that same cycle.
  - `win_cnt` ← 0 and `spk_cnt` ← 0; the next window starts immediately with no gap.
  - `isi_cnt`, `isi_last` and `have_prev` carry across windows.
- **Output register:**
  - At window end, if `out_valid` = 0, or `out_valid` = 1 and `out_ready` = 1 in the same cycle: load `rate_out`/`isi_out` with the new result and set `out_valid` ← 1.
  - Otherwise: drop the new result, keep the old data, and set `overrun` ← 1.
  - Handshake: when `out_valid`·`out_ready` = 1 and there is no window end in that cycle, `out_valid` ← 0.
  - Data is stable while `out_valid` = 1 and not accepted.
- **`overrun`:** cleared only by reset or by a `COUNT`→`IDLE` transition.
- **Widths:** `win_cnt` is 16 bits. All 8-bit counters saturate and never wrap.

## Timing
- **Reset values:** `rate_out` = 0, `isi_out` = 0, `out_valid` = 0, `overrun` = 0. Internally `spike_q` = 0, state = `IDLE`, and all counters = 0.
- **Input latency:** `spike` high before edge k is in `spike_q` after edge k and is counted at edge k+1.
- **Window length:** the first window starts with the first cycle in which `enable` is registered high as state `COUNT`. It covers exactly `WINDOW` `COUNT` cycles of `spike_q` samples.
- **Result latency:** `out_valid` rises and data updates at the edge that closes the window. Results appear every `WINDOW` cycles while the consumer keeps up.
- **Mid-window abort:** `enable` dropping mid-window discards the partial window (no output). A later re-enable starts a fresh window.
- **Reset:** `reset_n` asserted at any time clears everything asynchronously, including a pending result.

## Test plan
1. **Reset:** assert `reset_n` = 0 while `spike` = 1 and `enable` = 1; release. Required: all outputs 0; first `out_valid` occurs `WINDOW` cycles after the state enters `COUNT`.
2. **Regular train:** `WINDOW` = 16, `out_ready` = 1, one `spike` pulse every 4 cycles. Required: steady-state windows give `rate_out` = 4 and `isi_out` = 4, with `out_valid` pulsing once per 16 cycles.
3. **Saturation:** `WINDOW` = 300, `spike` held at 1. Required: `rate_out` = 255 and `isi_out` = 1. Then `WINDOW` = 600 with a single spike pair 400 cycles apart: required `isi_out` = 255.
4. **Backpressure:** `WINDOW` = 8, `out_ready` = 0 for 20 cycles. Required: the first result is held stable; the second window end sets `overrun` = 1. Raise `out_ready`: the first result is accepted, and the next window's result follows.
5. **Same-cycle accept:** `out_ready` = 1 exactly on a window-end cycle while `out_valid` = 1. Required: the new result loads, `out_valid` stays 1, and `overrun` stays 0.
6. **Abort:** drop `enable` after 5 cycles of an 8-cycle window containing 3 spikes, then re-enable. Required: no output for the partial window; the next result counts only spikes after re-enable; `isi_out` = 0 if fewer than two spikes; `overrun` cleared.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Spike-train readout stage for the LIF neuron.
// Over fixed windows of enabled cycles it measures the spike count (rate code)
// and the most recent inter-spike interval, then presents each finished window
// on a valid/ready output register. All 8-bit counters saturate at 255.
// The counting state is taken from the registered state, so the cycle in which
// enable falls still counts, and a window that closes in that cycle is still
// delivered. When an overrun and an abort land on the same edge, the abort
// clears overrun.
module spike_rate_decoder #(
  parameter int unsigned WINDOW = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spike,
  input  logic       enable,
  output logic [7:0] rate_out,
  output logic [7:0] isi_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [15:0] WinLast = 16'(WINDOW - 1);

  state_t      state_q, state_d;
  logic        spike_q;
  logic [15:0] win_cnt_q, win_cnt_d;
  logic [7:0]  spk_cnt_q, spk_cnt_d;
  logic [7:0]  isi_cnt_q, isi_cnt_d;
  logic [7:0]  isi_last_q, isi_last_d;
  logic        have_prev_q, have_prev_d;
  logic [7:0]  rate_q, rate_d;
  logic [7:0]  isi_q, isi_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;
  logic        win_end;
  logic [7:0]  result_rate;

  // Input register: the spike level is sampled every cycle, enabled or not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spike_q <= 1'b0;
    end else begin
      spike_q <= spike;
    end
  end

  // State register of the idle/count controller.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, window/ISI counters and output register update.
  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    spk_cnt_d   = spk_cnt_q;
    isi_cnt_d   = isi_cnt_q;
    isi_last_d  = isi_last_q;
    have_prev_d = have_prev_q;
    rate_d      = rate_q;
    isi_d       = isi_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    win_end     = 1'b0;
    result_rate = spk_cnt_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = COUNT;
        end
        win_cnt_d   = 16'd0;
        spk_cnt_d   = 8'd0;
        isi_cnt_d   = 8'd0;
        isi_last_d  = 8'd0;
        have_prev_d = 1'b0;
      end
      COUNT: begin
        if (!enable) begin
          state_d = IDLE;
        end
        win_end = (win_cnt_q == WinLast);
        if (spike_q && (spk_cnt_q != 8'hFF)) begin
          result_rate = spk_cnt_q + 8'd1;
        end
        win_cnt_d = win_end ? 16'd0 : (win_cnt_q + 16'd1);
        spk_cnt_d = win_end ? 8'd0 : result_rate;
        if (spike_q) begin
          if (have_prev_q) begin
            isi_last_d = isi_cnt_q;
          end
          isi_cnt_d   = 8'd1;
          have_prev_d = 1'b1;
        end else if (isi_cnt_q != 8'hFF) begin
          isi_cnt_d = isi_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (win_end) begin
      if (!valid_q || out_ready) begin
        rate_d  = result_rate;
        isi_d   = isi_last_d;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if ((state_q == COUNT) && !enable) begin
      overrun_d = 1'b0;
    end
  end

  // Measurement counters and the output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt_q   <= 16'd0;
      spk_cnt_q   <= 8'd0;
      isi_cnt_q   <= 8'd0;
      isi_last_q  <= 8'd0;
      have_prev_q <= 1'b0;
      rate_q      <= 8'd0;
      isi_q       <= 8'd0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      win_cnt_q   <= win_cnt_d;
      spk_cnt_q   <= spk_cnt_d;
      isi_cnt_q   <= isi_cnt_d;
      isi_last_q  <= isi_last_d;
      have_prev_q <= have_prev_d;
      rate_q      <= rate_d;
      isi_q       <= isi_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rate_out  = rate_q;
  assign isi_out   = isi_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Testbench for spike_rate_decoder: three instances with windows of 8, 16 and
// 300 share one stimulus stream. A reference model built on spike timestamps
// predicts every output after every clock edge; directed phases add fixed
// expectations for regular trains, saturation, backpressure and abort.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       spike;
  logic       enable;
  logic       out_ready;
  logic [7:0] rateO  [3];
  logic [7:0] isiO   [3];
  logic       validO [3];
  logic       ovrO   [3];

  int checks = 0;
  int passes = 0;

  int winLen [3] = '{8, 16, 300};

  // Reference model state, one slot per instance.
  bit mCount  [3];
  bit mSpikeQ [3];
  int winPos  [3];
  int winSpk  [3];
  int prevT   [3];
  int lastT   [3];
  int nowT    [3];
  int mRate   [3];
  int mIsi    [3];
  bit mValid  [3];
  bit mOvr    [3];

  spike_rate_decoder #(.WINDOW(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .spike(spike), .enable(enable),
    .rate_out(rateO[0]), .isi_out(isiO[0]), .out_valid(validO[0]),
    .out_ready(out_ready), .overrun(ovrO[0])
  );

  spike_rate_decoder #(.WINDOW(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .spike(spike), .enable(enable),
    .rate_out(rateO[1]), .isi_out(isiO[1]), .out_valid(validO[1]),
    .out_ready(out_ready), .overrun(ovrO[1])
  );

  spike_rate_decoder #(.WINDOW(300)) dut300 (
    .clk(clk), .reset_n(reset_n), .spike(spike), .enable(enable),
    .rate_out(rateO[2]), .isi_out(isiO[2]), .out_valid(validO[2]),
    .out_ready(out_ready), .overrun(ovrO[2])
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end else begin
      passes++;
    end
  endtask

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      mCount[i]  = 1'b0;
      mSpikeQ[i] = 1'b0;
      winPos[i]  = 0;
      winSpk[i]  = 0;
      prevT[i]   = -1;
      lastT[i]   = -1;
      nowT[i]    = 0;
      mRate[i]   = 0;
      mIsi[i]    = 0;
      mValid[i]  = 1'b0;
      mOvr[i]    = 1'b0;
    end
  endtask

  // One clock edge of the model, using the input values present at that edge.
  task automatic modelStep(input bit en, input bit sp, input bit rdy);
    for (int i = 0; i < 3; i++) begin
      bit ended;
      ended = 1'b0;
      if (mCount[i]) begin
        if (mSpikeQ[i]) begin
          prevT[i] = lastT[i];
          lastT[i] = nowT[i];
          winSpk[i]++;
        end
        winPos[i]++;
        if (winPos[i] == winLen[i]) begin
          ended = 1'b1;
          if (!mValid[i] || rdy) begin
            mRate[i]  = sat255(winSpk[i]);
            mIsi[i]   = (prevT[i] >= 0) ? sat255(lastT[i] - prevT[i]) : 0;
            mValid[i] = 1'b1;
          end else begin
            mOvr[i] = 1'b1;
          end
          winPos[i] = 0;
          winSpk[i] = 0;
        end
        nowT[i]++;
        if (!en) begin
          mOvr[i] = 1'b0;
        end
      end else begin
        winPos[i] = 0;
        winSpk[i] = 0;
        prevT[i]  = -1;
        lastT[i]  = -1;
      end
      if (!ended && mValid[i] && rdy) begin
        mValid[i] = 1'b0;
      end
      mCount[i]  = en;
      mSpikeQ[i] = sp;
    end
  endtask

  task automatic compareAll();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("w%0d.rate", winLen[i]), 16'(rateO[i]), 16'(mRate[i]));
      checkOutput($sformatf("w%0d.isi", winLen[i]), 16'(isiO[i]), 16'(mIsi[i]));
      checkOutput($sformatf("w%0d.valid", winLen[i]), 16'(validO[i]), 16'(mValid[i]));
      checkOutput($sformatf("w%0d.overrun", winLen[i]), 16'(ovrO[i]), 16'(mOvr[i]));
    end
  endtask

  // Asserts reset with spike and enable high, checks the asynchronous clear,
  // then releases it and checks the first edge afterwards.
  task automatic doReset();
    @(negedge clk);
    reset_n   = 1'b0;
    spike     = 1'b1;
    enable    = 1'b1;
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rst.w%0d.rate", winLen[i]), 16'(rateO[i]), 16'd0);
      checkOutput($sformatf("rst.w%0d.isi", winLen[i]), 16'(isiO[i]), 16'd0);
      checkOutput($sformatf("rst.w%0d.valid", winLen[i]), 16'(validO[i]), 16'd0);
      checkOutput($sformatf("rst.w%0d.overrun", winLen[i]), 16'(ovrO[i]), 16'd0);
    end
    modelReset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    modelStep(enable, spike, out_ready);
    #1;
    compareAll();
  endtask

  // Drives n cycles of one stimulus mode and checks every edge.
  // 0 random, 1 regular train, 2 held spike, 3 heavy backpressure,
  // 4 spike pair 400 apart, 5 frequent aborts, 6 sparse spikes,
  // 7 ready low for 20 cycles, 8 abort of a partial window.
  task automatic applyStimulus(input int mode, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      enable    = 1'b1;
      out_ready = 1'b1;
      case (mode)
        0: begin
          spike     = ($urandom_range(0, 3) == 0);
          out_ready = ($urandom_range(0, 1) == 1);
          enable    = ($urandom_range(0, 99) != 0);
        end
        1: spike = ((c % 4) == 0);
        2: spike = 1'b1;
        3: begin
          spike     = ($urandom_range(0, 2) == 0);
          out_ready = ($urandom_range(0, 19) == 0);
        end
        4: spike = (c == 10) || (c == 410);
        5: begin
          spike     = ($urandom_range(0, 1) == 1);
          out_ready = ($urandom_range(0, 3) != 0);
          enable    = ($urandom_range(0, 5) != 0);
        end
        6: spike = ($urandom_range(0, 39) == 0);
        7: begin
          spike     = ($urandom_range(0, 1) == 1);
          out_ready = (c >= 20);
        end
        8: begin
          spike  = (c == 0) || (c == 2) || (c == 4) || (c == 10);
          enable = (c < 5) || (c >= 8);
        end
        default: spike = 1'b0;
      endcase
      @(posedge clk);
      modelStep(enable, spike, out_ready);
      #1;
      compareAll();
      if (mode == 1 && c >= 40 && validO[1]) begin
        checkOutput("train.w16.rate", 16'(rateO[1]), 16'd4);
        checkOutput("train.w16.isi", 16'(isiO[1]), 16'd4);
      end
      if (mode == 1 && c >= 40 && validO[0]) begin
        checkOutput("train.w8.rate", 16'(rateO[0]), 16'd2);
        checkOutput("train.w8.isi", 16'(isiO[0]), 16'd4);
      end
      if (mode == 2 && c >= 320 && validO[2]) begin
        checkOutput("held.w300.rate", 16'(rateO[2]), 16'd255);
        checkOutput("held.w300.isi", 16'(isiO[2]), 16'd1);
      end
      if (mode == 4 && c >= 420 && validO[1]) begin
        checkOutput("pair.w16.isi", 16'(isiO[1]), 16'd255);
      end
      if (mode == 4 && c >= 720 && validO[2]) begin
        checkOutput("pair.w300.isi", 16'(isiO[2]), 16'd255);
      end
      if (mode == 7 && c == 19) begin
        checkOutput("bp.w8.overrun", 16'(ovrO[0]), 16'd1);
      end
      if (mode == 8 && c == 16) begin
        checkOutput("abort.w8.valid", 16'(validO[0]), 16'd1);
        checkOutput("abort.w8.rate", 16'(rateO[0]), 16'd1);
        checkOutput("abort.w8.isi", 16'(isiO[0]), 16'd0);
      end
      if (mode == 8 && c == 29) begin
        checkOutput("abort.w8.rate2", 16'(rateO[0]), 16'd0);
        checkOutput("abort.w8.isi2", 16'(isiO[0]), 16'd0);
        checkOutput("abort.w16.isi", 16'(isiO[1]), 16'd0);
        checkOutput("abort.w8.overrun", 16'(ovrO[0]), 16'd0);
        checkOutput("abort.w16.overrun", 16'(ovrO[1]), 16'd0);
      end
    end
  endtask

  // Top-level sequence of phases.
  initial begin
    reset_n   = 1'b0;
    spike     = 1'b1;
    enable    = 1'b1;
    out_ready = 1'b0;
    modelReset();
    doReset();
    applyStimulus(1, 200);
    applyStimulus(2, 700);
    applyStimulus(4, 1000);
    applyStimulus(8, 30);
    applyStimulus(7, 60);
    applyStimulus(0, 3000);
    applyStimulus(3, 800);
    applyStimulus(5, 1500);
    doReset();
    applyStimulus(0, 1000);
    applyStimulus(6, 1500);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
